// File: rtl/count_sched.sv
// Round-robin time-sliced scheduler for a shared counter.
// Grants are capped at SLICE cycles and followed by one dead cycle.
module count_sched #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int SLICE = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             en_o,
  output logic             busy_o,
  output logic             expire_o,
  output logic [WIDTH-1:0] slice_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] HANDOFF = 2'd2;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(SLICE - 1);
  localparam logic [IW-1:0]    TOP  = IW'(N_REQ - 1);
  localparam logic [IW:0]      NQ   = (IW+1)'(N_REQ);

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] slice_q, slice_d;
  logic             exp_q, exp_d;

  logic [IW-1:0]    win;
  logic [N_REQ-1:0] win_oh;
  logic             found;
  logic [IW:0]      sum;
  logic [IW-1:0]    idx;

  logic any_req;
  logic busy;
  logic req_gnt;
  logic rel;
  logic hit_last;
  logic [IW-1:0] ptr_inc;

  // Search upward from ptr with wrap; first asserted bit wins.
  always_comb begin
    win    = '0;
    win_oh = '0;
    found  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr_q} + (IW+1)'(i);
      if (sum >= NQ) begin
        sum = sum - NQ;
      end
      idx = sum[IW-1:0];
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        win         = idx;
        win_oh[idx] = 1'b1;
      end
    end
  end

  assign any_req  = |req_i;
  assign busy     = (state_q == GRANT);
  assign req_gnt  = req_i[gidx_q];
  assign rel      = !req_gnt;
  assign hit_last = (slice_q == LAST);
  assign ptr_inc  = (gidx_q == TOP) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    gnt_d   = gnt_q;
    slice_d = slice_q;
    exp_d   = 1'b0;
    unique case (state_q)
      IDLE, HANDOFF: begin
        if (any_req) begin
          state_d = GRANT;
          gidx_d  = win;
          gnt_d   = win_oh;
          slice_d = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel || hit_last) begin
          // Release wins over expiry, so no pulse then.
          state_d = HANDOFF;
          gnt_d   = '0;
          ptr_d   = ptr_inc;
          exp_d   = !rel;
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      gnt_q   <= '0;
      slice_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      gnt_q   <= gnt_d;
      slice_q <= slice_d;
      exp_q   <= exp_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign busy_o   = busy;
  assign en_o     = busy & req_gnt;
  assign expire_o = exp_q;
  assign slice_o  = slice_q;

endmodule

// File: doc/count_sched.md
COUNT_SCHED -- requirements
Module: count_sched

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the counter; legal range 2..8.
REQ-002 Parameter WIDTH, default 4: width of the internal slice counter.
REQ-003 Parameter SLICE, default 8: maximum grant length in cycles; legal range 2..2**WIDTH.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 req_i  input  N_REQ  per-requester request for the shared counter, level-sensitive.
REQ-007 gnt_o  output  N_REQ  registered grant, one-hot or all-zero.
REQ-008 en_o  output  1  enable to the shared counter's en_i.
REQ-009 busy_o  output  1  high while the FSM is in GRANT.
REQ-010 expire_o  output  1  one-cycle pulse: the previous grant ended by slice expiry.
REQ-011 slice_o  output  WIDTH  current slice count (cycles consumed by the active grant, minus one).

Function
REQ-012 FSM states SHALL be IDLE, GRANT and HANDOFF; encoding is free.
REQ-013 IDLE: gnt_o=0; if any req_i bit is high, the block SHALL go to GRANT next edge with gnt_o set to the arbitration winner.
REQ-014 Arbitration SHALL be round-robin: the winner is the first asserted req_i bit at or after pointer ptr, searching upward with wrap from N_REQ-1 to 0.
REQ-015 Grant latency SHALL be exactly one cycle from req_i sampled high (IDLE or HANDOFF) to gnt_o high.
REQ-016 GRANT: slice_o SHALL be 0 in the first grant cycle and increment by 1 each subsequent GRANT cycle.
REQ-017 en_o SHALL equal busy_o AND req_i[granted index] (combinational); en_o SHALL be 0 outside GRANT.
REQ-018 Release: if req_i[granted] is low in a GRANT cycle, the block SHALL go to HANDOFF next edge.
REQ-019 Expiry: if slice_o == SLICE-1 in a GRANT cycle and the request is still high, the block SHALL go to HANDOFF next edge and pulse expire_o for that HANDOFF cycle.
REQ-020 If release and expiry coincide, release SHALL take priority and expire_o SHALL stay 0.
REQ-021 On leaving GRANT, ptr SHALL become (granted index + 1) mod N_REQ.
REQ-022 HANDOFF: gnt_o=0 and en_o=0 for exactly one cycle (dead cycle).
REQ-023 HANDOFF exit: go to GRANT with the new winner if any req_i bit is high; otherwise go to IDLE.
REQ-024 A requester that just expired and is still requesting SHALL be re-granted only if no other requester is asserting.
REQ-025 Changes on non-granted req_i bits during GRANT SHALL NOT affect gnt_o, slice_o or the exit timing.
REQ-026 slice_o SHALL reset to 0 on entry to GRANT and hold its last value in IDLE and HANDOFF.

Reset
REQ-027 While rst_ni=0: state=IDLE, ptr=0, gnt_o=0, en_o=0, busy_o=0, expire_o=0, slice_o=0, all taking effect asynchronously.
REQ-028 Reset assertion mid-GRANT SHALL drop gnt_o and en_o immediately, without waiting for a clock edge.
REQ-029 After rst_ni deasserts, the first grant SHALL follow REQ-013 from ptr=0.

Verification
REQ-030 Defaults, req_i=4'b0000 after reset: all outputs 0 for 10 cycles, and a count module on en_o holds 0.
REQ-031 req_i=4'b0001 held: gnt_o=0001 for 8 cycles (slice_o 0..7); then HANDOFF with expire_o=1; then re-grant to 0001; the counter advances by exactly 8 per 9 cycles.
REQ-032 req_i=4'b1111 held: grants cycle 0001, 0010, 0100, 1000, 0001, each 8 cycles long, each followed by one cycle with gnt_o=0.
REQ-033 req_i=4'b0100, dropped at grant cycle 3: grant lasts 3 cycles with en_o=1 and one cycle with en_o=0; then HANDOFF with expire_o=0, then IDLE; the next grant search starts at index 3.
REQ-034 Simultaneous release and expiry (req dropped when slice_o==7): HANDOFF with expire_o=0.
REQ-035 rst_ni pulsed low during a grant at slice_o=5: gnt_o, en_o and slice_o are 0 before the next edge; with req_i=4'b1010 after release, the first grant is 0010.
